// File: rtl/mac_feeder.sv
// mac_feeder: buffers one NMAX-pair dot-product vector from an upstream
// valid/ready stream, replays it into the MAC as a gapless burst with ena
// held high, and captures the MAC result for a downstream valid/ready port.
// Optional protocol checking (sticky err, DRAIN timeout) is enabled by
// defining MAC_FEEDER_CHECK_EN; when undefined err is tied low.
module mac_feeder #(
   parameter int DW   = 32,
   parameter int NMAX = 64,
   parameter int CW   = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic [DW-1:0] in_weight,
   output logic [DW-1:0] mac_data,
   output logic [DW-1:0] mac_weight,
   output logic          mac_ena,
   input  logic [DW-1:0] mac_result,
   input  logic          mac_cnt_c,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_result,
   output logic          busy,
   output logic          err
);

   typedef enum logic [1:0] {
      S_FILL,
      S_ARMED,
      S_STREAM,
      S_DRAIN
   } state_t;

   localparam logic [CW-1:0] LAST = CW'(NMAX - 1);

   state_t          state_q, state_d;
   logic [CW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   beat_q, beat_d;
   logic [DW-1:0]   mac_data_q, mac_data_d;
   logic [DW-1:0]   mac_weight_q, mac_weight_d;
   logic            out_valid_q, out_valid_d;
   logic [DW-1:0]   out_result_q, out_result_d;
   logic            wr_en;
   logic [2*DW-1:0] buf_q [NMAX];

`ifdef MAC_FEEDER_CHECK_EN
   logic            err_q, err_d;
   logic [1:0]      drain_cnt_q, drain_cnt_d;
`endif

   // Pair buffer: {data, weight} written at wr_ptr; contents need no reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         buf_q[wr_ptr_q] <= {in_data, in_weight};
      end
   end

   // Next-state, operand fetch, result capture and output handshake.
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      beat_d       = beat_q;
      mac_data_d   = '0;
      mac_weight_d = '0;
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      wr_en        = 1'b0;
`ifdef MAC_FEEDER_CHECK_EN
      err_d        = err_q;
      drain_cnt_d  = '0;
`endif

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      // Capture wins over the handshake; ARMED guarantees they never meet.
      if (mac_cnt_c) begin
         out_valid_d  = 1'b1;
         out_result_d = mac_result;
      end

      case (state_q)
         S_FILL: begin
            if (in_valid) begin
               wr_en = 1'b1;
               if (wr_ptr_q == LAST) begin
                  wr_ptr_d = '0;
                  state_d  = S_ARMED;
               end else begin
                  wr_ptr_d = wr_ptr_q + 1'b1;
               end
            end
         end
         S_ARMED: begin
            if (!out_valid_q || out_ready) begin
               state_d                    = S_STREAM;
               beat_d                     = '0;
               {mac_data_d, mac_weight_d} = buf_q[0];
            end
         end
         S_STREAM: begin
            if (beat_q == LAST) begin
               beat_d = '0;
               // A zero-latency MAC may strobe on the final beat itself.
               state_d = mac_cnt_c ? S_FILL : S_DRAIN;
            end else begin
               beat_d                     = beat_q + 1'b1;
               {mac_data_d, mac_weight_d} = buf_q[beat_q + 1'b1];
            end
         end
         S_DRAIN: begin
            beat_d = '0;
            if (mac_cnt_c) begin
               state_d = S_FILL;
            end
`ifdef MAC_FEEDER_CHECK_EN
            else if (drain_cnt_q == 2'd3) begin
               state_d = S_FILL;
               err_d   = 1'b1;
            end else begin
               drain_cnt_d = drain_cnt_q + 2'd1;
            end
`endif
         end
         default: state_d = S_FILL;
      endcase

`ifdef MAC_FEEDER_CHECK_EN
      if (mac_cnt_c && !(state_q == S_DRAIN ||
                         (state_q == S_STREAM && beat_q == LAST))) begin
         err_d = 1'b1;
      end
`endif
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_FILL;
         wr_ptr_q     <= '0;
         beat_q       <= '0;
         mac_data_q   <= '0;
         mac_weight_q <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
`ifdef MAC_FEEDER_CHECK_EN
         err_q        <= 1'b0;
         drain_cnt_q  <= '0;
`endif
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         beat_q       <= beat_d;
         mac_data_q   <= mac_data_d;
         mac_weight_q <= mac_weight_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
`ifdef MAC_FEEDER_CHECK_EN
         err_q        <= err_d;
         drain_cnt_q  <= drain_cnt_d;
`endif
      end
   end

   assign in_ready   = (state_q == S_FILL);
   assign mac_ena    = (state_q == S_STREAM);
   assign mac_data   = mac_data_q;
   assign mac_weight = mac_weight_q;
   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign busy       = (state_q != S_FILL) || (wr_ptr_q != '0);
`ifdef MAC_FEEDER_CHECK_EN
   assign err        = err_q;
`else
   assign err        = 1'b0;
`endif

endmodule
